// File: rtl/avalon_pio_in_edge_pkg.sv
// Shared constants and helpers for the avalon_pio_in_edge parallel input port.
// The optional debounce filter is controlled by the PIO_IN_DEBOUNCE_EN macro.
package avalon_pio_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Ceiling log2; clog2(1) = 0, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_pio_in_edge_if.sv
// Avalon-MM slave signal bundle for the avalon_pio_in_edge register block.
interface avalon_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_pio_in_edge_debounce.sv
// Per-bit debounce filter for avalon_pio_in_edge; only built when
// PIO_IN_DEBOUNCE_EN is defined. The filtered output follows the synchronised
// input once the two have disagreed for DEBOUNCE_CYCLES consecutive cycles.
`ifdef PIO_IN_DEBOUNCE_EN
module pio_bit_debounce
    import avalon_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    output logic f_out
);
    localparam int CNT_W = (clog2(DEBOUNCE_CYCLES + 1) > 0) ? clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int LAST  = (DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt_r;
    logic             f_r;

    // Count consecutive disagreeing cycles; adopt the new level when the window fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
            f_r   <= 1'b0;
        end else if (s_in == f_r) begin
            cnt_r <= '0;
        end else if (cnt_r >= CNT_LAST) begin
            f_r   <= s_in;
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign f_out = f_r;
endmodule
`endif

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM read-only parallel input port with synchroniser, per-bit edge
// capture (write-1-to-clear) and a maskable level interrupt.
// Optional feature macro: PIO_IN_DEBOUNCE_EN (per-bit debounce filter).
module avalon_pio_in_edge
    import avalon_pio_pkg::*;
#(
    parameter int          DATA_WIDTH      = 16,
    parameter int          SYNC_STAGES     = 2,
    parameter int          EDGE_TYPE       = 0,
    parameter logic [31:0] IRQ_MASK_RESET  = 32'd0,
    parameter int          DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_pio_in_edge_if.slave   avs,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    // Capture is held off until the synchroniser holds post-reset samples only.
    localparam int ARM_COUNT = SYNC_STAGES + 1;
    localparam int ARM_W     = clog2(ARM_COUNT + 1);
    localparam logic [ARM_W-1:0]      ARM_DONE  = ARM_W'(ARM_COUNT);
    localparam logic [DATA_WIDTH-1:0] MASK_INIT = IRQ_MASK_RESET[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] s_in_s;
    logic [DATA_WIDTH-1:0] f_in_s;
    logic [DATA_WIDTH-1:0] prev_r;
    logic [DATA_WIDTH-1:0] edge_s;
    logic [DATA_WIDTH-1:0] edgecap_r;
    logic [DATA_WIDTH-1:0] irqmask_r;
    logic [DATA_WIDTH-1:0] ec_clr_s;
    logic [ARM_W-1:0]      arm_cnt_r;
    logic                  armed_s;
    logic                  wr_en_s;
    logic                  mask_we_s;
    logic [31:0]           rd_next_s;
    logic [31:0]           readdata_r;
    logic                  irq_r;

    // Resynchronise the asynchronous inputs into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign s_in_s = sync_r[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_debounce
        pio_bit_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .s_in  (s_in_s[g]),
            .f_out (f_in_s[g])
        );
    end
`else
    assign f_in_s = s_in_s;
`endif

    // Count cycles since reset release; saturates once capture is armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_r <= '0;
        end else if (arm_cnt_r != ARM_DONE) begin
            arm_cnt_r <= arm_cnt_r + 1'b1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    assign armed_s = (arm_cnt_r == ARM_DONE);

    // Select which transitions of the filtered input count as events.
    always_comb begin
        edge_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = f_in_s & ~prev_r;
            EDGE_FALL: edge_s = ~f_in_s & prev_r;
            EDGE_ANY:  edge_s = f_in_s ^ prev_r;
            default:   edge_s = f_in_s & ~prev_r;
        endcase
    end

    // Decode bus writes into mask load and edge-capture clear.
    always_comb begin
        wr_en_s   = avs.chipselect & ~avs.write_n;
        mask_we_s = 1'b0;
        ec_clr_s  = '0;
        if (wr_en_s) begin
            case (avs.address)
                ADDR_IRQMASK: mask_we_s = 1'b1;
                ADDR_EDGECAP: ec_clr_s  = avs.writedata[DATA_WIDTH-1:0];
                default: begin
                    mask_we_s = 1'b0;
                    ec_clr_s  = '0;
                end
            endcase
        end else begin
            mask_we_s = 1'b0;
            ec_clr_s  = '0;
        end
    end

    // Previous filtered value, edge capture (new edge beats clear) and mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r    <= '0;
            edgecap_r <= '0;
            irqmask_r <= MASK_INIT;
        end else begin
            prev_r    <= f_in_s;
            edgecap_r <= (edgecap_r & ~ec_clr_s) | (edge_s & {DATA_WIDTH{armed_s}});
            if (mask_we_s) begin
                irqmask_r <= avs.writedata[DATA_WIDTH-1:0];
            end else begin
                irqmask_r <= irqmask_r;
            end
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero.
    always_comb begin
        rd_next_s = 32'd0;
        case (avs.address)
            ADDR_DATA:    rd_next_s[DATA_WIDTH-1:0] = f_in_s;
            ADDR_IRQMASK: rd_next_s[DATA_WIDTH-1:0] = irqmask_r;
            ADDR_EDGECAP: rd_next_s[DATA_WIDTH-1:0] = edgecap_r;
            default:      rd_next_s = 32'd0;
        endcase
    end

    // Registered read data and level interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= rd_next_s;
            irq_r      <= |(edgecap_r & irqmask_r);
        end
    end

    assign avs.readdata = readdata_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for avalon_pio_in_edge: a 16-bit rising-edge instance and an 8-bit
// any-edge instance, each compared every cycle against a behavioural model,
// plus directed checks with hand-computed values.
module tb_avalon_pio_in_edge;
    import avalon_pio_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int DEB_LAT = DEB;
`else
    localparam int DEB_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_a;
    logic [7:0]  in_b;
    logic        irq_a;
    logic        irq_b;

    avalon_pio_in_edge_if if_a ();
    avalon_pio_in_edge_if if_b ();

    always #5 clk = ~clk;

    avalon_pio_in_edge #(
        .DATA_WIDTH (16), .SYNC_STAGES (SYNC), .EDGE_TYPE (0),
        .IRQ_MASK_RESET (32'd0), .DEBOUNCE_CYCLES (DEB)
    ) dut_a (
        .clk (clk), .reset (reset), .avs (if_a.slave), .in_port (in_a), .irq (irq_a)
    );

    avalon_pio_in_edge #(
        .DATA_WIDTH (8), .SYNC_STAGES (SYNC), .EDGE_TYPE (2),
        .IRQ_MASK_RESET (32'd0), .DEBOUNCE_CYCLES (DEB)
    ) dut_b (
        .clk (clk), .reset (reset), .avs (if_b.slave), .in_port (in_b), .irq (irq_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state, index 0 = dut_a, 1 = dut_b.
    logic [31:0] m_hist [2][8];
    logic [31:0] m_f    [2];
    logic [31:0] m_fold [2];
    logic [31:0] m_ec   [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];
    int          m_kc   [2];
    int          m_cnt  [2][32];
    bit          m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the port, computed from the register-map rules.
    task automatic model_step(input int id, input int w, input int et, input logic rst,
                              input logic [31:0] inp, input logic cs, input logic wn,
                              input logic [1:0] addr, input logic [31:0] wd);
        logic [31:0] wmask, s_old, f_new, edg, clr;
        bit          wr;
        wmask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_hist[id][i] = 32'd0;
            for (int b = 0; b < 32; b++) m_cnt[id][b] = 0;
            m_f[id] = 32'd0; m_fold[id] = 32'd0; m_ec[id] = 32'd0;
            m_mask[id] = 32'd0; m_rd[id] = 32'd0; m_irq[id] = 1'b0; m_kc[id] = 0;
        end else begin
            wr = cs && !wn;
            case (addr)
                2'd0:    m_rd[id] = m_f[id];
                2'd2:    m_rd[id] = m_mask[id];
                2'd3:    m_rd[id] = m_ec[id];
                default: m_rd[id] = 32'd0;
            endcase
            m_irq[id] = |(m_ec[id] & m_mask[id]);
            case (et)
                0:       edg = m_f[id] & ~m_fold[id];
                1:       edg = ~m_f[id] & m_fold[id];
                default: edg = m_f[id] ^ m_fold[id];
            endcase
            if (m_kc[id] < SYNC + 1) edg = 32'd0;
            clr = (wr && addr == 2'd3) ? (wd & wmask) : 32'd0;
            m_ec[id] = (m_ec[id] & ~clr) | edg;
            if (wr && addr == 2'd2) m_mask[id] = wd & wmask;
            s_old = m_hist[id][SYNC-1];
            for (int i = 7; i > 0; i--) m_hist[id][i] = m_hist[id][i-1];
            m_hist[id][0] = inp & wmask;
`ifdef PIO_IN_DEBOUNCE_EN
            f_new = m_f[id];
            for (int b = 0; b < w; b++) begin
                if (s_old[b] != m_f[id][b]) begin
                    if (m_cnt[id][b] == DEB - 1) begin
                        f_new[b] = s_old[b];
                        m_cnt[id][b] = 0;
                    end else begin
                        m_cnt[id][b]++;
                    end
                end else begin
                    m_cnt[id][b] = 0;
                end
            end
`else
            f_new = m_hist[id][SYNC-1];
`endif
            m_fold[id] = m_f[id];
            m_f[id]    = f_new;
            if (m_kc[id] < 1000) m_kc[id]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 16, 0, reset, {16'h0, in_a}, if_a.chipselect, if_a.write_n,
                   if_a.address, if_a.writedata);
        model_step(1, 8, 2, reset, {24'h0, in_b}, if_b.chipselect, if_b.write_n,
                   if_b.address, if_b.writedata);
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rd_a",  if_a.readdata, m_rd[0]);
            check("model_irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
            check("model_rd_b",  if_b.readdata, m_rd[1]);
            check("model_irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
        end
    end

    task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
        if_a.chipselect = 1'b1; if_a.write_n = 1'b0; if_a.address = a; if_a.writedata = d;
        @(negedge clk);
        if_a.chipselect = 1'b0; if_a.write_n = 1'b1;
    endtask

    task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
        if_b.chipselect = 1'b1; if_b.write_n = 1'b0; if_b.address = a; if_b.writedata = d;
        @(negedge clk);
        if_b.chipselect = 1'b0; if_b.write_n = 1'b1;
    endtask

    task automatic rd_a(input string name, input logic [1:0] a, input logic [31:0] exp);
        if_a.address = a;
        @(negedge clk);
        check(name, if_a.readdata, exp);
    endtask

    task automatic rd_b(input string name, input logic [1:0] a, input logic [31:0] exp);
        if_b.address = a;
        @(negedge clk);
        check(name, if_b.readdata, exp);
    endtask

    initial begin
        reset = 1'b1; in_a = 16'hFFFF; in_b = 8'h00;
        if_a.chipselect = 1'b0; if_a.write_n = 1'b1; if_a.address = 2'd0; if_a.writedata = 32'd0;
        if_b.chipselect = 1'b0; if_b.write_n = 1'b1; if_b.address = 2'd0; if_b.writedata = 32'd0;
        repeat (4) @(negedge clk);
        check("reset_rd_a", if_a.readdata, 32'd0);
        check("reset_irq_a", {31'd0, irq_a}, 32'd0);

        // Inputs high across reset release
        reset = 1'b0;
        repeat (10 + DEB_LAT) @(negedge clk);
        rd_a("reset_hi_data", ADDR_DATA, 32'h0000_FFFF);
`ifdef PIO_IN_DEBOUNCE_EN
        rd_a("reset_hi_edgecap", ADDR_EDGECAP, 32'h0000_FFFF);
`else
        rd_a("reset_hi_edgecap", ADDR_EDGECAP, 32'h0000_0000);
`endif
        check("reset_hi_irq", {31'd0, irq_a}, 32'd0);
        rd_b("reset_b_data", ADDR_DATA, 32'd0);
        in_a = 16'h0000;
        repeat (8 + DEB_LAT) @(negedge clk);
        wr_a(ADDR_EDGECAP, 32'h0000_FFFF);

        // Writes to DATA are ignored
        wr_a(ADDR_DATA, 32'hFFFF_FFFF);
        rd_a("data_write_ignored", ADDR_DATA, 32'd0);

`ifndef PIO_IN_DEBOUNCE_EN
        // Rising capture: one-cycle pulse on bit 3
        if_a.address = ADDR_EDGECAP;
        in_a = 16'h0008; @(negedge clk);
        in_a = 16'h0000; @(negedge clk);
        @(negedge clk); check("rise_ec_early", if_a.readdata, 32'd0);
        @(negedge clk); check("rise_ec_set", if_a.readdata, 32'h8);
        repeat (3) @(negedge clk);
        rd_a("rise_data_back", ADDR_DATA, 32'd0);
        check("rise_irq_masked", {31'd0, irq_a}, 32'd0);

        // Interrupt assert and clear
        wr_a(ADDR_EDGECAP, 32'h8);
        wr_a(ADDR_IRQMASK, 32'h8);
        rd_a("mask_readback", ADDR_IRQMASK, 32'h8);
        check("irq_idle", {31'd0, irq_a}, 32'd0);
        in_a = 16'h0008; @(negedge clk);
        in_a = 16'h0000; @(negedge clk);
        @(negedge clk); check("irq_early", {31'd0, irq_a}, 32'd0);
        @(negedge clk); check("irq_set", {31'd0, irq_a}, 32'd1);
        wr_a(ADDR_EDGECAP, 32'h8);
        check("irq_hold", {31'd0, irq_a}, 32'd1);
        @(negedge clk); check("irq_clear", {31'd0, irq_a}, 32'd0);

        // Clear colliding with a new edge: the edge wins
        in_a = 16'h0008; @(negedge clk);
        in_a = 16'h0000; repeat (4) @(negedge clk);
        in_a = 16'h0008; @(negedge clk);
        in_a = 16'h0000; @(negedge clk);
        wr_a(ADDR_EDGECAP, 32'h8);
        @(negedge clk); check("collision_keep", if_a.readdata, 32'h8);
        check("collision_irq", {31'd0, irq_a}, 32'd1);
        wr_a(ADDR_EDGECAP, 32'h8);
        wr_a(ADDR_IRQMASK, 32'h0);
        repeat (2) @(negedge clk);
`else
        // Debounce: short glitch rejected, long pulse accepted
        if_a.address = ADDR_DATA;
        in_a = 16'h0001; repeat (10) @(negedge clk);
        in_a = 16'h0000; repeat (40) @(negedge clk);
        rd_a("glitch_data", ADDR_DATA, 32'd0);
        rd_a("glitch_ec", ADDR_EDGECAP, 32'd0);
        if_a.address = ADDR_DATA;
        in_a = 16'h0001;
        repeat (18) @(negedge clk); check("deb_data_early", if_a.readdata, 32'd0);
        @(negedge clk); check("deb_data_set", if_a.readdata, 32'd1);
        @(negedge clk);
        in_a = 16'h0000;
        repeat (4) @(negedge clk);
        rd_a("deb_ec", ADDR_EDGECAP, 32'd1);
        repeat (24) @(negedge clk);
        wr_a(ADDR_EDGECAP, 32'h1);
`endif

        // Any-edge instance, 8 bits wide
        in_b = 8'h0F; repeat (10 + DEB_LAT) @(negedge clk);
        in_b = 8'h05; repeat (10 + DEB_LAT) @(negedge clk);
        rd_b("any_ec", ADDR_EDGECAP, 32'h0F);
        wr_b(ADDR_RSVD, 32'hFFFF_FFFF);
        rd_b("any_rsvd", ADDR_RSVD, 32'd0);
        rd_b("any_ec_unchanged", ADDR_EDGECAP, 32'h0F);
        rd_b("any_data", ADDR_DATA, 32'h05);
        wr_b(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd_b("mask_b_width", ADDR_IRQMASK, 32'h0000_00FF);
        check("irq_b_set", {31'd0, irq_b}, 32'd1);
        wr_b(ADDR_EDGECAP, 32'hFFFF_FFFF);
        rd_b("any_ec_cleared", ADDR_EDGECAP, 32'd0);
        check("irq_b_clear", {31'd0, irq_b}, 32'd0);

        // Reset mid-operation with inputs high
        wr_a(ADDR_IRQMASK, 32'h8);
        in_a = 16'hFFFF;
        reset = 1'b1; repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_a("midreset_mask", ADDR_IRQMASK, 32'd0);
        repeat (10 + DEB_LAT) @(negedge clk);
`ifndef PIO_IN_DEBOUNCE_EN
        rd_a("midreset_ec", ADDR_EDGECAP, 32'd0);
`endif
        rd_a("midreset_data", ADDR_DATA, 32'h0000_FFFF);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
